// File: rtl/wb_regfile.sv
// Writeback stage and 32x32 integer register file: selects the writeback value, stores it,
// serves two combinational read ports with write-to-read bypass and counts retired writes.
module wb_regfile #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned NREG = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            RegWrite_i,
  input  logic [1:0]      MemtoReg_i,
  input  logic [XLEN-1:0] MemAddr_i,
  input  logic [XLEN-1:0] MemReadData_i,
  input  logic [4:0]      WriteRegDest_i,
  input  logic [XLEN-1:0] PC_i,
  input  logic [4:0]      rs1_addr_i,
  input  logic [4:0]      rs2_addr_i,
  output logic [XLEN-1:0] rs1_data_o,
  output logic [XLEN-1:0] rs2_data_o,
  output logic [XLEN-1:0] wb_data_o,
  output logic [4:0]      wb_rd_o,
  output logic            wb_we_o,
  output logic [31:0]     retire_cnt_o
);

  localparam logic [XLEN-1:0] LinkOffset = XLEN'(4);

  logic [XLEN-1:0] r_regs [NREG];
  logic [31:0]     r_retire_cnt;

  logic [XLEN-1:0] w_wb_data;
  logic [XLEN-1:0] w_link_addr;
  logic            w_we;

  assign w_link_addr = PC_i + LinkOffset;

  // Encoding 2'b11 is reserved and falls back to the ALU result.
  always_comb begin
    w_wb_data = MemAddr_i;
    unique case (MemtoReg_i)
      2'b00:   w_wb_data = MemAddr_i;
      2'b01:   w_wb_data = MemReadData_i;
      2'b10:   w_wb_data = w_link_addr;
      default: w_wb_data = MemAddr_i;
    endcase
  end

  // Reset gates the enable so forwarding and the bypass never see a write that will be dropped.
  assign w_we = RegWrite_i && (WriteRegDest_i != 5'd0) && !rst_i;

  assign wb_data_o    = w_wb_data;
  assign wb_rd_o      = WriteRegDest_i;
  assign wb_we_o      = w_we;
  assign retire_cnt_o = r_retire_cnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(NREG); i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_we) begin
      r_regs[WriteRegDest_i] <= w_wb_data;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_retire_cnt <= '0;
    end else if (w_we) begin
      r_retire_cnt <= r_retire_cnt + 32'd1;
    end
  end

  always_comb begin
    rs1_data_o = '0;
    if (rst_i || rs1_addr_i == 5'd0) begin
      rs1_data_o = '0;
    end else if (w_we && rs1_addr_i == WriteRegDest_i) begin
      rs1_data_o = w_wb_data;
    end else begin
      rs1_data_o = r_regs[rs1_addr_i];
    end
  end

  always_comb begin
    rs2_data_o = '0;
    if (rst_i || rs2_addr_i == 5'd0) begin
      rs2_data_o = '0;
    end else if (w_we && rs2_addr_i == WriteRegDest_i) begin
      rs2_data_o = w_wb_data;
    end else begin
      rs2_data_o = r_regs[rs2_addr_i];
    end
  end

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: mux select, link wrap, x0 protection, bypass, reset
// behaviour and retire counter wrap.
module tb_wb_regfile;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        RegWrite_i;
  logic [1:0]  MemtoReg_i;
  logic [31:0] MemAddr_i;
  logic [31:0] MemReadData_i;
  logic [4:0]  WriteRegDest_i;
  logic [31:0] PC_i;
  logic [4:0]  rs1_addr_i;
  logic [4:0]  rs2_addr_i;
  logic [31:0] rs1_data_o;
  logic [31:0] rs2_data_o;
  logic [31:0] wb_data_o;
  logic [4:0]  wb_rd_o;
  logic        wb_we_o;
  logic [31:0] retire_cnt_o;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] mux_exp [4];

  always #5 clk_i = ~clk_i;

  wb_regfile #(.XLEN(32), .NREG(32)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .RegWrite_i    (RegWrite_i),
    .MemtoReg_i    (MemtoReg_i),
    .MemAddr_i     (MemAddr_i),
    .MemReadData_i (MemReadData_i),
    .WriteRegDest_i(WriteRegDest_i),
    .PC_i          (PC_i),
    .rs1_addr_i    (rs1_addr_i),
    .rs2_addr_i    (rs2_addr_i),
    .rs1_data_o    (rs1_data_o),
    .rs2_data_o    (rs2_data_o),
    .wb_data_o     (wb_data_o),
    .wb_rd_o       (wb_rd_o),
    .wb_we_o       (wb_we_o),
    .retire_cnt_o  (retire_cnt_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // Inputs change just after the falling edge; checks land 1 time unit later, before the rise.
  task automatic tick();
    @(negedge clk_i);
  endtask

  task automatic drive_wb(input logic we, input logic [1:0] sel, input logic [4:0] rd,
                          input logic [31:0] addr);
    RegWrite_i     = we;
    MemtoReg_i     = sel;
    WriteRegDest_i = rd;
    MemAddr_i      = addr;
    #1;
  endtask

  initial begin
    mux_exp[0] = 32'h0000_000A;
    mux_exp[1] = 32'h0000_000B;
    mux_exp[2] = 32'h0000_0104;
    mux_exp[3] = 32'h0000_000A;

    rst_i = 1'b1;
    RegWrite_i = 1'b0; MemtoReg_i = 2'b00; MemAddr_i = '0; MemReadData_i = '0;
    WriteRegDest_i = '0; PC_i = '0; rs1_addr_i = '0; rs2_addr_i = '0;
    #12;
    rs1_addr_i = 5'd3; #1;
    check("reset_rs1", rs1_data_o, 32'h0);
    check("reset_cnt", retire_cnt_o, 32'h0);
    check("reset_we", {31'b0, wb_we_o}, 32'h0);

    tick();
    rst_i = 1'b0;

    // Writeback mux sweep into x3.
    MemReadData_i = 32'hB; PC_i = 32'h100;
    for (int s = 0; s < 4; s++) begin
      drive_wb(1'b1, 2'(s), 5'd3, 32'hA);
      check($sformatf("mux_sel%0d", s), wb_data_o, mux_exp[s]);
      tick();
    end
    check("wb_rd_fwd", {27'b0, wb_rd_o}, 32'd3);
    drive_wb(1'b0, 2'b00, 5'd3, 32'hA);
    check("x3_stored", rs1_data_o, 32'hA);
    check("cnt_after_mux", retire_cnt_o, 32'd4);

    // Link address wraps modulo 2^32.
    drive_wb(1'b1, 2'b00, 5'd31, 32'h77);
    tick();
    PC_i = 32'hFFFF_FFFC;
    drive_wb(1'b1, 2'b10, 5'd31, 32'h0);
    check("pc4_wrap_wbdata", wb_data_o, 32'h0);
    tick();
    drive_wb(1'b0, 2'b00, 5'd0, 32'h0);
    rs2_addr_i = 5'd31; #1;
    check("x31_wrap", rs2_data_o, 32'h0);
    check("cnt_after_wrap", retire_cnt_o, 32'd6);

    // x0 is never written nor counted.
    rs1_addr_i = 5'd0; rs2_addr_i = 5'd0;
    drive_wb(1'b1, 2'b00, 5'd0, 32'hDEAD_BEEF);
    check("x0_we", {31'b0, wb_we_o}, 32'h0);
    check("x0_read", rs1_data_o, 32'h0);
    tick();
    drive_wb(1'b0, 2'b00, 5'd0, 32'h0);
    check("x0_read_after", rs2_data_o, 32'h0);
    check("x0_cnt", retire_cnt_o, 32'd6);

    // Same-cycle bypass on both ports, then storage.
    rs1_addr_i = 5'd7; rs2_addr_i = 5'd7;
    drive_wb(1'b1, 2'b00, 5'd7, 32'h55);
    check("byp_rs1", rs1_data_o, 32'h55);
    check("byp_rs2", rs2_data_o, 32'h55);
    tick();
    drive_wb(1'b0, 2'b00, 5'd7, 32'h99);
    check("store_rs1", rs1_data_o, 32'h55);
    check("store_rs2", rs2_data_o, 32'h55);
    check("no_byp_when_off", wb_data_o == 32'h99 ? rs1_data_o : 32'hFFFF_FFFF, 32'h55);

    // Back-to-back writes to x7.
    drive_wb(1'b1, 2'b00, 5'd7, 32'h11);
    check("b2b_first", rs1_data_o, 32'h11);
    tick();
    drive_wb(1'b1, 2'b00, 5'd7, 32'h22);
    check("b2b_second", rs2_data_o, 32'h22);
    tick();
    drive_wb(1'b0, 2'b00, 5'd0, 32'h0);
    check("b2b_stored", rs1_data_o, 32'h22);
    check("cnt_after_b2b", retire_cnt_o, 32'd9);

    // Asynchronous reset mid-cycle.
    rs1_addr_i = 5'd5; rs2_addr_i = 5'd5;
    drive_wb(1'b1, 2'b00, 5'd5, 32'h1234);
    tick();
    drive_wb(1'b0, 2'b00, 5'd0, 32'h0);
    check("x5_written", rs1_data_o, 32'h1234);
    check("cnt_before_rst", retire_cnt_o, 32'd10);
    #2;
    rst_i = 1'b1; #1;
    check("rst_async_x5", rs1_data_o, 32'h0);
    check("rst_async_cnt", retire_cnt_o, 32'h0);
    drive_wb(1'b1, 2'b01, 5'd5, 32'h0);
    MemReadData_i = 32'hCAFE; #1;
    check("rst_no_bypass", rs2_data_o, 32'h0);
    check("rst_we_forced", {31'b0, wb_we_o}, 32'h0);
    check("rst_wbdata_follows", wb_data_o, 32'hCAFE);
    tick();
    check("rst_cnt_hold", retire_cnt_o, 32'h0);
    rst_i = 1'b0;
    drive_wb(1'b0, 2'b00, 5'd0, 32'h0);
    check("x5_after_rst", rs1_data_o, 32'h0);
    drive_wb(1'b1, 2'b00, 5'd5, 32'h66);
    tick();
    drive_wb(1'b0, 2'b00, 5'd0, 32'h0);
    check("first_write_after_rst", rs1_data_o, 32'h66);
    check("cnt_after_rst", retire_cnt_o, 32'd1);

    // Counter wrap via preload of the counter state.
    force dut.r_retire_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.r_retire_cnt;
    #1;
    check("cnt_preload", retire_cnt_o, 32'hFFFF_FFFF);
    drive_wb(1'b1, 2'b00, 5'd9, 32'h9);
    tick();
    drive_wb(1'b0, 2'b00, 5'd0, 32'h0);
    check("cnt_wrap", retire_cnt_o, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/wb_regfile.md
# wb_regfile

Writeback stage and integer register file of the five-stage pipeline, sitting directly downstream of the MEM/WB pipeline register. Each cycle it selects the writeback value from the ALU result, the load data or the link address (PC+4), writes it into a 32×32-bit register file, and serves two combinational read ports to the ID stage with internal write-to-read bypass. It also exports the current writeback value to the EX-stage forwarding unit and keeps a 32-bit count of retired register writes.

## Interface
- `XLEN`, 32, datapath width.
- `NREG`, 32, number of architectural registers; register 0 is hardwired to zero.

Ports:
- `clk_i` input 1: clock, all state updates on the rising edge.
- `rst_i` input 1: reset, asynchronous, active-high.
- `RegWrite_i` input 1: writeback enable from MEM/WB.
- `MemtoReg_i` input 2: writeback source select from MEM/WB.
- `MemAddr_i` input XLEN: ALU result or memory address from MEM/WB.
- `MemReadData_i` input XLEN: load data from MEM/WB.
- `WriteRegDest_i` input 5: destination register index.
- `PC_i` input XLEN: PC of the instruction in WB.
- `rs1_addr_i` input 5: ID read port 1 index.
- `rs2_addr_i` input 5: ID read port 2 index.
- `rs1_data_o` output XLEN: read port 1 data.
- `rs2_data_o` output XLEN: read port 2 data.
- `wb_data_o` output XLEN: selected writeback value, for forwarding.
- `wb_rd_o` output 5: destination index, forwarded as-is.
- `wb_we_o` output 1: effective write enable, for forwarding.
- `retire_cnt_o` output 32: number of effective register writes since reset.

## Operation
- Writeback mux, combinational:
  - `MemtoReg_i` = 00 selects `MemAddr_i`.
  - 01 selects `MemReadData_i`.
  - 10 selects `PC_i + 4`, computed modulo 2^XLEN.
  - 11 is reserved and selects `MemAddr_i`.
- Effective write enable: `wb_we_o = RegWrite_i && (WriteRegDest_i != 0)`.
- Register write: on a rising edge with `wb_we_o`=1, `reg[WriteRegDest_i] <= wb_data_o`. No other register changes.
- Register 0 always reads 0. It never stores a value, and a write to it has no effect and is not counted.
- Read ports, combinational, per port:
  - Index 0 returns 0.
  - If `wb_we_o` is 1 and the index equals `WriteRegDest_i`, the port returns `wb_data_o` (bypass).
  - Otherwise the port returns the stored `reg[index]`.
- Both ports may address the same register; they are independent and return identical data.
- Retire counter: increments by 1 on every rising edge where `wb_we_o` is 1. It wraps from 0xFFFFFFFF to 0 with no sticky flag.
- `wb_data_o`, `wb_rd_o` and `wb_we_o` are pure functions of the current inputs; they are not registered.

## Timing
- Reset (`rst_i`=1) takes effect immediately, independent of the clock:
  - all registers 1..31 are cleared to 0;
  - `retire_cnt_o` is cleared to 0;
  - while reset is asserted, writes are blocked and the counter holds at 0.
- Output values during reset:
  - `rs1_data_o` and `rs2_data_o` return 0 for any index. The bypass is suppressed while `rst_i`=1.
  - `wb_data_o`, `wb_rd_o` and `wb_we_o` follow their inputs, except that `wb_we_o` is forced to 0 while in reset.
- Reset asserted mid-operation discards any write in flight for that edge.
- The first edge after `rst_i` falls performs a normal write if `wb_we_o`=1.
- Write latency: a value is stored at the edge ending the WB cycle. Through the bypass it is visible to ID reads in that same cycle. From the next cycle onward it is visible from storage.
- Read latency: zero cycles, combinational from the `rs*_addr_i` inputs and the WB inputs.
- Back-to-back writes to the same register on consecutive cycles: each cycle's bypass shows that cycle's value, and storage holds the latest written value.

## Test plan
- **Reset:** assert `rst_i` asynchronously mid-cycle after writing `x5`=0x1234 → `rs1_data_o`(x5)=0 immediately, `retire_cnt_o`=0; after release, x5 still reads 0.
- **Mux select:** with `MemAddr_i`=0xA, `MemReadData_i`=0xB, `PC_i`=0x100, `rd`=3, `RegWrite_i`=1, sweep `MemtoReg_i` = 00/01/10/11 → `wb_data_o` = 0xA/0xB/0x104/0xA; x3 holds 0xA at the end; `retire_cnt_o`=4.
- **PC+4 wrap:** `PC_i`=0xFFFFFFFC, `MemtoReg_i`=10, `rd`=31 → x31=0x00000000.
- **x0 protection:** `RegWrite_i`=1, `rd`=0, `MemAddr_i`=0xDEADBEEF → `wb_we_o`=0; reading x0 returns 0; `retire_cnt_o` unchanged.
- **Bypass:** write x7=0x55 while `rs1_addr_i`=`rs2_addr_i`=7 in the same cycle → both ports return 0x55 before the edge. Next cycle, with `RegWrite_i`=0, both still return 0x55. With `RegWrite_i`=0 and `rd`=7, the bypass is not taken and the old value is returned.
- **Counter wrap:** force 2^32−1 effective writes (or preload via a test hook), then one more write → `retire_cnt_o`=0.
